// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM states, note-table entry layout,
// the end-of-sequence marker and a default melody table for a 25 MHz clock.
package note_seq_pkg;

  localparam int DELTA_W = 32;
  // Entry layout is {delta, dur}: the duration sits in the low bits, the delta above it.
  localparam int DUR_LSB = 0;
  localparam int DUR_END = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_END
  } state_t;

  // Phase increment for a tone of f_hz: f * 2^32 / clk_hz.
  function automatic logic [DELTA_W-1:0] calc_delta(input longint unsigned f_hz,
                                                   input longint unsigned clk_hz);
    return DELTA_W'((f_hz << 32) / clk_hz);
  endfunction

  localparam int DEF_CLK_HZ    = 25_000_000;
  localparam int DEF_DUR_W     = 8;
  localparam int DEF_NUM_NOTES = 16;

  localparam logic [DELTA_W-1:0] DELTA_C4 = calc_delta(262, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_D4 = calc_delta(294, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_E4 = calc_delta(330, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_F4 = calc_delta(349, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_G4 = calc_delta(392, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_A4 = calc_delta(440, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_B4 = calc_delta(494, DEF_CLK_HZ);
  localparam logic [DELTA_W-1:0] DELTA_C5 = calc_delta(523, DEF_CLK_HZ);

  function automatic logic [DELTA_W+DEF_DUR_W-1:0] def_entry(input logic [DELTA_W-1:0] delta,
                                                             input logic [DEF_DUR_W-1:0] dur);
    return {delta, dur};
  endfunction

  // C major scale, 200 ticks per note, then end markers. Entry 0 is the rightmost field.
  localparam logic [DEF_NUM_NOTES*(DELTA_W+DEF_DUR_W)-1:0] DEFAULT_TABLE = {
    {8{def_entry('0, 8'(DUR_END))}},
    def_entry(DELTA_C5, 8'd200), def_entry(DELTA_B4, 8'd200),
    def_entry(DELTA_A4, 8'd200), def_entry(DELTA_G4, 8'd200),
    def_entry(DELTA_F4, 8'd200), def_entry(DELTA_E4, 8'd200),
    def_entry(DELTA_D4, 8'd200), def_entry(DELTA_C4, 8'd200)
  };

endpackage

// File: rtl/note_table_rom.sv
// Synchronous-read note table: data appears one clock after the address.
// Contents are supplied as a flat parameter vector, entry i at bits [i*ENTRY_W +: ENTRY_W].
module note_table_rom
  import note_seq_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  parameter int ENTRY_W   = DELTA_W + DEF_DUR_W,
  parameter logic [NUM_NOTES*ENTRY_W-1:0] TABLE = '0
) (
  input  logic                         clk,
  input  logic [$clog2(NUM_NOTES)-1:0] addr,
  output logic [ENTRY_W-1:0]           data
);

  // NOTE: the read register has no reset on purpose; it is only consumed one cycle
  // after FETCH has driven a valid address, so its power-up value never matters.
  always_ff @(posedge clk) begin
    data <= TABLE[int'(addr)*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks the note table, strobes each phase increment into the
// accumulator and times note/gap durations with a tick prescaler.
// Build option: define NOTE_SEQ_LOOP_EN to replay the table continuously until stopped.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int TICK_HZ   = 1_000,
  parameter int NUM_NOTES = 16,
  parameter int DUR_W     = 8,
  parameter logic [NUM_NOTES*(DELTA_W+DUR_W)-1:0] TABLE = DEFAULT_TABLE
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  output logic [DELTA_W-1:0]           o_phase_delta,
  output logic                         o_phase_delta_valid,
  output logic                         o_gate,
  output logic                         o_busy,
  output logic [$clog2(NUM_NOTES)-1:0] o_note_index,
  output logic                         o_done
);

  localparam int IDX_W     = $clog2(NUM_NOTES);
  localparam int ENTRY_W   = DELTA_W + DUR_W;
  localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] TICK_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_NOTES - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   index_next;
  logic [PRE_W-1:0]   presc, presc_next;
  logic [DUR_W-1:0]   dur_cnt, dur_cnt_next;
  logic [DELTA_W-1:0] delta_next;
  logic               valid_next, gate_next, done_next;
  logic               tick;
  logic [ENTRY_W-1:0] rom_data;
  logic [DUR_W-1:0]   rom_dur;
  logic [DELTA_W-1:0] rom_delta;

  note_table_rom #(
    .NUM_NOTES (NUM_NOTES),
    .ENTRY_W   (ENTRY_W),
    .TABLE     (TABLE)
  ) u_rom (
    .clk  (i_clk),
    .addr (o_note_index),
    .data (rom_data)
  );

  assign rom_dur   = rom_data[DUR_LSB +: DUR_W];
  assign rom_delta = rom_data[DUR_LSB + DUR_W +: DELTA_W];
  assign tick      = (presc == TICK_LAST);
  assign o_busy    = (state != ST_IDLE);

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    index_next   = o_note_index;
    presc_next   = presc;
    dur_cnt_next = dur_cnt;
    delta_next   = o_phase_delta;
    valid_next   = 1'b0;
    gate_next    = o_gate;
    done_next    = 1'b0;

    if (state != ST_IDLE) begin
      presc_next = tick ? '0 : presc + 1'b1;
    end

    if (i_stop && state != ST_IDLE) begin
      state_next = ST_IDLE;
      gate_next  = 1'b0;
      delta_next = '0;
      valid_next = 1'b1;
      presc_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            state_next = ST_FETCH;
            index_next = '0;
            presc_next = '0;
          end
        end
        ST_FETCH: state_next = ST_LOAD;
        ST_LOAD: begin
          if (rom_dur == DUR_W'(DUR_END)) begin
            state_next = ST_END;
          end else begin
            delta_next   = rom_delta;
            valid_next   = 1'b1;
            gate_next    = 1'b1;
            dur_cnt_next = rom_dur;
            // Realign the prescaler so the note lasts exactly dur full ticks.
            presc_next   = '0;
            state_next   = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            dur_cnt_next = dur_cnt - 1'b1;
            if (dur_cnt == DUR_W'(1)) begin
              gate_next  = 1'b0;
              state_next = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (o_note_index == LAST_INDEX) begin
              state_next = ST_END;
            end else begin
              index_next = o_note_index + 1'b1;
              state_next = ST_FETCH;
            end
          end
        end
        ST_END: begin
          done_next = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
          state_next = ST_FETCH;
          index_next = '0;
`else
          state_next = ST_IDLE;
          delta_next = '0;
          valid_next = 1'b1;
`endif
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= ST_IDLE;
      o_note_index        <= '0;
      presc               <= '0;
      dur_cnt             <= '0;
      o_phase_delta       <= '0;
      o_phase_delta_valid <= 1'b0;
      o_gate              <= 1'b0;
      o_done              <= 1'b0;
    end else begin
      state               <= state_next;
      o_note_index        <= index_next;
      presc               <= presc_next;
      dur_cnt             <= dur_cnt_next;
      o_phase_delta       <= delta_next;
      o_phase_delta_valid <= valid_next;
      o_gate              <= gate_next;
      o_done              <= done_next;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (short table with end marker, full 16-entry
// table) driven by directed and random start/stop, checked against a timeline model.
module tb_note_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int TD      = CLK_HZ / TICK_HZ;
  localparam int N       = 16;
  localparam int DUR_W   = 8;
  localparam int EW      = 32 + DUR_W;

  localparam logic [31:0] DA = 32'h0123_4567;
  localparam logic [31:0] DB = 32'h089A_BCDE;

  localparam logic [N*EW-1:0] TABLE_A = {{13{40'h0}}, {32'h0, 8'd0}, {DB, 8'd2}, {DA, 8'd3}};

  function automatic logic [N*EW-1:0] full_table();
    logic [N*EW-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) t[i*EW +: EW] = {32'h1000_0000 + 32'(i) * 32'h0011_0000, 8'd1};
    return t;
  endfunction

  localparam logic [N*EW-1:0] TABLE_F = full_table();

`ifdef NOTE_SEQ_LOOP_EN
  localparam int  EXP_STROBES = 2;
  localparam bit  EXP_BUSY_78 = 1'b1;
`else
  localparam int  EXP_STROBES = 3;
  localparam bit  EXP_BUSY_78 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  stop = '0;
  logic [31:0] delta [2];
  logic [1:0]  valid, gate, busy, done;
  logic [3:0]  index [2];

  always #5 clk = ~clk;

  note_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_NOTES(N), .DUR_W(DUR_W),
                   .TABLE(TABLE_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_stop(stop[0]),
    .o_phase_delta(delta[0]), .o_phase_delta_valid(valid[0]), .o_gate(gate[0]),
    .o_busy(busy[0]), .o_note_index(index[0]), .o_done(done[0]));

  note_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_NOTES(N), .DUR_W(DUR_W),
                   .TABLE(TABLE_F)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_stop(stop[1]),
    .o_phase_delta(delta[1]), .o_phase_delta_valid(valid[1]), .o_gate(gate[1]),
    .o_busy(busy[1]), .o_note_index(index[1]), .o_done(done[1]));

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  string nm [2] = '{"tblA", "full"};

  // Timeline model: note i fetches at o_tab[i] cycles after start, strobes at +2,
  // gates for dur*TD cycles, then one TD gap; e_end is the cycle END is entered.
  logic [31:0] m_dlt [2][N];
  int          m_dur [2][N];
  int          o_tab [2][N+1];
  int          k_end [2];
  int          e_end [2];
  bit          m_act [2];
  int          m_t [2];
  logic [31:0] m_delta [2];
  int          m_index [2];
  bit          e_valid [2], e_done [2], e_gate [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic build(input int d, input logic [N*EW-1:0] tbl);
    o_tab[d][0] = 0;
    k_end[d] = N;
    for (int i = 0; i < N; i++) begin
      m_dlt[d][i] = tbl[i*EW + DUR_W +: 32];
      m_dur[d][i] = int'(tbl[i*EW +: DUR_W]);
    end
    for (int i = 0; i < N; i++) begin
      if (m_dur[d][i] == 0) begin
        k_end[d] = i;
        break;
      end
      o_tab[d][i+1] = o_tab[d][i] + 2 + m_dur[d][i] * TD + TD;
    end
    e_end[d] = (k_end[d] < N) ? o_tab[d][k_end[d]] + 2 : o_tab[d][N];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_t[d] = 0; m_delta[d] = '0; m_index[d] = 0;
      e_valid[d] = 1'b0; e_done[d] = 1'b0; e_gate[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit st, input bit sp);
    e_valid[d] = 1'b0;
    e_done[d]  = 1'b0;
    if (m_act[d]) begin
      if (sp) begin
        m_act[d] = 1'b0; e_valid[d] = 1'b1; m_delta[d] = '0;
      end else begin
        m_t[d]++;
        if (m_t[d] == e_end[d] + 1) begin
          e_done[d] = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
          m_t[d] = 0; m_index[d] = 0;
`else
          m_act[d] = 1'b0; e_valid[d] = 1'b1; m_delta[d] = '0;
`endif
        end else begin
          for (int i = 0; i <= k_end[d] && i < N; i++) begin
            if (i < k_end[d] && m_t[d] == o_tab[d][i] + 2) begin
              e_valid[d] = 1'b1; m_delta[d] = m_dlt[d][i];
            end
            if (i > 0 && m_t[d] == o_tab[d][i]) m_index[d] = i;
          end
        end
      end
    end else if (st && !sp) begin
      m_act[d] = 1'b1; m_t[d] = 0; m_index[d] = 0;
    end
    e_gate[d] = 1'b0;
    if (m_act[d])
      for (int i = 0; i < k_end[d]; i++)
        if (m_t[d] >= o_tab[d][i] + 2 && m_t[d] < o_tab[d][i] + 2 + m_dur[d][i] * TD)
          e_gate[d] = 1'b1;
  endtask

  task automatic compare(input int d);
    check({nm[d], ".delta"}, delta[d], m_delta[d]);
    check({nm[d], ".valid"}, 32'(valid[d]), 32'(e_valid[d]));
    check({nm[d], ".gate"},  32'(gate[d]),  32'(e_gate[d]));
    check({nm[d], ".busy"},  32'(busy[d]),  32'(m_act[d]));
    check({nm[d], ".index"}, 32'(index[d]), 32'(m_index[d]));
    check({nm[d], ".done"},  32'(done[d]),  32'(e_done[d]));
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, ".", nm[d], ".delta"}, delta[d], 32'h0);
      check({tag, ".", nm[d], ".outs"}, {27'h0, valid[d], gate[d], busy[d], done[d], |index[d]}, 32'h0);
    end
  endtask

  task automatic step(input bit s0, input bit p0, input bit s1, input bit p1);
    @(negedge clk);
    start = {s1, s0};
    stop  = {p1, p0};
    @(posedge clk);
    #1;
    cyc++;
    model_step(0, s0, p0);
    model_step(1, s1, p1);
    compare(0);
    compare(1);
  endtask

  initial begin
    int n_strobe, n_gate, n_done, first_v;
    bool_busy_78: begin end
    build(0, TABLE_A);
    build(1, TABLE_F);
    model_reset();

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    // Uninterrupted run of both tables; a start pulse mid-note must be ignored.
    n_strobe = 0; n_gate = 0; n_done = 0; first_v = -1;
    step(1, 0, 1, 0);
    for (int c = 1; c <= 400; c++) begin
      step(c == 20, 0, c == 20, 0);
      if (c <= 78) begin
        n_strobe += int'(valid[0]);
        n_gate   += int'(gate[0]);
        n_done   += int'(done[0]);
        if (valid[0] && first_v < 0) first_v = c;
      end
      if (c == 78) check("A.busy_after_end", 32'(busy[0]), 32'(EXP_BUSY_78));
    end
    check("A.first_valid_latency", 32'(first_v), 32'd2);
    check("A.strobe_count", 32'(n_strobe), 32'(EXP_STROBES));
    check("A.gate_cycles", 32'(n_gate), 32'd50);
    check("A.done_count", 32'(n_done), 32'd1);

    // Start and stop together: stop wins.
    step(1, 1, 1, 1);
    repeat (4) step(0, 0, 0, 0);

    // Stop 5 cycles into note A.
    step(1, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    check("stop.gate_low", 32'(gate[0]), 32'd0);
    repeat (4) step(0, 0, 0, 0);

    // Asynchronous reset in the middle of a note.
    step(1, 0, 1, 0);
    repeat (15) step(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    // Random start/stop traffic.
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
